// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    localparam int          STARVE_CNT_W = 4;
    localparam logic [31:0] ABORT_DATA   = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline fetch/data ports, the arbiter and the unified memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          err;

    // Arbiter side
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, err
    );

    // Pipeline + memory side
    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, err
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog for mem_arbiter; only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic busy,
    input  logic ready,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt;

    // Loaded on grant; expire fires in the TIMEOUT-th busy cycle without ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (busy && !ready && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = busy && !ready && (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for IF fetch and MEM data ports; data has priority, fetch is
// protected by a starvation counter. Optional watchdog abort under MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          rstn,
    mem_arbiter_if.master bus
);

    //  state  | meaning
    //  IDLE   | arbitrate; held one extra cycle while an ack is out
    //  I_BUSY | fetch transaction on the memory, waiting for mem_ready
    //  D_BUSY | load/store transaction on the memory, waiting for mem_ready

    if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_bad_starve_lim
        $error("mem_arbiter: STARVE_LIM must be in 1..15");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

    localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(STARVE_LIM);

    state_t                  state, state_nxt;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    grant_d, grant_i, done, abort, expire;

    logic          mem_req_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] if_rdata_q, d_rdata_q;
    logic          if_ack_q, d_ack_q, err_q;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .start  (grant_d | grant_i),
        .busy   (state != IDLE),
        .ready  (bus.mem_ready),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                // The requester still holds req during its ack cycle; arbitrating
                // then would issue the same access twice.
                if (!(if_ack_q || d_ack_q)) begin
                    if (bus.d_req && ((starve_cnt < LIM) || !bus.if_req)) begin
                        grant_d   = 1'b1;
                        state_nxt = D_BUSY;
                    end else if (bus.if_req) begin
                        grant_i   = 1'b1;
                        state_nxt = I_BUSY;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.mem_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (expire) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            if (grant_d) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= bus.d_we;
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
            end else if (grant_i) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= bus.if_addr;
                mem_wdata_q <= '0;
            end
            if (done || abort) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
                err_q     <= abort;
                if (state == I_BUSY) begin
                    if_ack_q   <= 1'b1;
                    if_rdata_q <= abort ? DW'(ABORT_DATA) : bus.mem_rdata;
                end else begin
                    d_ack_q   <= 1'b1;
                    d_rdata_q <= abort ? DW'(ABORT_DATA) :
                                 (mem_we_q ? '0 : bus.mem_rdata);
                end
            end
        end
    end

    // Counts data grants that bypassed a waiting fetch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!bus.if_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIM) begin
                starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
            end
        end else if (grant_i) begin
            starve_cnt <= '0;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port unified instruction/data memory between the IF-stage fetch port and the MEM-stage data port (lw/sw) of the five-stage MIPS pipeline. Issues one memory transaction at a time and holds it until the memory handshakes. Returns a one-cycle acknowledge to the winning requester; the hazard/stall logic uses that acknowledge to freeze the requesting stage until it arrives. Data accesses take priority, and a starvation counter bounds how long fetch can be locked out.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIM, 4, consecutive data grants allowed while fetch is pending; range 1..15
- TIMEOUT, 64, cycles to wait for mem_ready before abort; only used under MEM_ARB_TIMEOUT_EN

Ports:
- clk  in  1  rising-edge clock; one clock domain
- rstn  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction; valid only while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held with d_we, d_addr, d_wdata until d_ack
- d_we  in  1  1=store (sw), 0=load (lw)
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid only while d_ack=1
- d_ack  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request, level
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid when mem_ready=1
- mem_ready  in  1  memory completion, single-cycle
- err  out  1  one-cycle timeout pulse; constant 0 without MEM_ARB_TIMEOUT_EN

## Operation
- FSM states and transitions:
  - IDLE: arbitrate.
    - d_req and (starve_cnt<STARVE_LIM or !if_req): go to D_BUSY.
    - else if_req: go to I_BUSY.
    - else: stay in IDLE.
- Grant effects:
  - Grant registers the winner's address, we and wdata into the mem_* outputs.
  - mem_we is forced to 0 for a fetch.
- D_BUSY / I_BUSY:
  - mem_req=1; mem_* outputs held stable.
  - On mem_ready: capture mem_rdata into the winner's rdata register, pulse the winner's ack, go to IDLE.
- IDLE always lasts at least one cycle after an ack. The requester's req is still asserted in the ack cycle, so re-arbitrating there would duplicate the access.
- Starvation counter starve_cnt (4 bits):
  - +1 on each data grant while if_req=1, saturating at STARVE_LIM.
  - Cleared on any fetch grant.
  - Cleared on any data grant while if_req=0.
- Requests withdrawn before their ack are illegal. The arbiter completes the memory transaction and still pulses ack.
- Loads and stores both complete with d_ack; d_rdata is don't-care for stores and driven 0.

## Timing
- Reset values: state=IDLE, starve_cnt=0; mem_req, mem_we, if_ack, d_ack and err all 0; mem_addr, mem_wdata, if_rdata, d_rdata all 0.
- Reset mid-transaction abandons the transaction immediately: no ack, mem_req low asynchronously.
- Latency with a zero-wait memory (mem_ready high in the first busy cycle):
  - req sampled at edge 0 (IDLE to BUSY).
  - mem_req high in cycle 1.
  - ack high in cycle 2.
- Request-to-ack latency is 2 + wait cycles.
- Peak throughput: one access per 3 cycles (BUSY, ack/IDLE, arbitrate).
- if_ack and d_ack are never high in the same cycle.
- Simultaneous if_req and d_req in IDLE with starve_cnt<STARVE_LIM: data wins.
- Simultaneous requests with starve_cnt==STARVE_LIM: fetch wins.
- mem_ready outside BUSY is ignored.

## Configuration
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined: a watchdog counts BUSY cycles without mem_ready.
  - On reaching TIMEOUT: pulse err, pulse the winner's ack with rdata=32'hDEAD_BEEF, drop mem_req, go to IDLE.
  - The counter clears on every grant.
- Undefined: no watchdog; BUSY waits indefinitely; err tied 0.

## Structure
- Package mem_arb_pkg holds:
  - state enum: IDLE, I_BUSY, D_BUSY
  - STARVE_CNT_W=4
  - ABORT_DATA=32'hDEAD_BEEF
- One sub-module, mem_arb_watchdog, compiled only under MEM_ARB_TIMEOUT_EN.
  - Ports: clk, rstn, start, busy, ready.
  - Output: expire.

## Test plan
- Single load, zero-wait: d_req=1, d_we=0, d_addr=0x100, mem_rdata=0x1234_5678 → mem_req in cycle 1, d_ack with d_rdata=0x1234_5678 in cycle 2, mem_we=0.
- Simultaneous requests: if_req and d_req asserted together and held → d_ack first, then if_ack three cycles later; never both high in one cycle.
- Starvation: d_req held continuously, if_req held, STARVE_LIM=4 → 4 data grants, 5th grant goes to fetch, starve_cnt back to 0.
- Wait states and store: d_we=1, d_wdata=0xCAFE_F00D, mem_ready delayed 5 cycles → mem_addr/mem_wdata stable throughout, d_ack in cycle 7.
- Reset mid-transaction: rstn low during I_BUSY → mem_req drops immediately, no if_ack; after release, a pending if_req is re-served from IDLE.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=8): fetch with mem_ready never asserted → err and if_ack pulse together with if_rdata=0xDEAD_BEEF, FSM returns to IDLE.
